// File: rtl/decode_format_arbiter_pkg.sv
// Shared decode definitions: format one-hot codes, functional-unit IDs
// and the major-ID width that the arbiter and the output mux agree on.
package decode_format_arbiter_pkg;

    localparam int INSTR_CNT_W = 64;
    localparam int FORMAT_W    = 25;

    localparam logic [FORMAT_W-1:0] FMT_A = FORMAT_W'(1 << 9);
    localparam logic [FORMAT_W-1:0] FMT_B = FORMAT_W'(1 << 1);
    localparam logic [FORMAT_W-1:0] FMT_D = FORMAT_W'(1 << 5);

    typedef enum logic [2:0] {
        FU_ALU,
        FU_MUL,
        FU_LSU,
        FU_BRU,
        FU_CSR
    } func_unit_e;

    typedef enum logic [1:0] {
        SRC_A,
        SRC_B,
        SRC_D,
        SRC_NONE
    } src_e;

endpackage

// File: rtl/decode_format_fifo.sv
// Small per-format FIFO; one instance buffers one decoder's output.
module decode_format_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Pointers are PTR_W wide, so the increments wrap modulo DEPTH.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/decode_format_arbiter.sv
// Merges the A/B/D decoder streams oldest-major-ID-first into one
// registered valid/ready output, with per-format backpressure.
module decode_format_arbiter
    import decode_format_arbiter_pkg::*;
#(
    parameter int instructionCounterWidth = INSTR_CNT_W,
    parameter int payloadWidth            = 256,
    parameter int fifoDepth               = 2,
    parameter int fifoPtrWidth            = 1,
    parameter int formatWidth             = FORMAT_W
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               AEnable_i,
    input  logic                               BEnable_i,
    input  logic                               DEnable_i,
    input  logic [instructionCounterWidth-1:0] AMajId_i,
    input  logic [instructionCounterWidth-1:0] BMajId_i,
    input  logic [instructionCounterWidth-1:0] DMajId_i,
    input  logic [payloadWidth-1:0]            APayload_i,
    input  logic [payloadWidth-1:0]            BPayload_i,
    input  logic [payloadWidth-1:0]            DPayload_i,
    output logic                               AReady_o,
    output logic                               BReady_o,
    output logic                               DReady_o,
    output logic                               outValid_o,
    input  logic                               outReady_i,
    output logic [formatWidth-1:0]             outFormat_o,
    output logic [instructionCounterWidth-1:0] outMajId_o,
    output logic [payloadWidth-1:0]            outPayload_o,
    output logic [2+fifoPtrWidth-1:0]          occupancy_o
);

    localparam int IW      = instructionCounterWidth;
    localparam int ENTRY_W = IW + payloadWidth;
    localparam int OCC_W   = 2 + fifoPtrWidth;

    logic [ENTRY_W-1:0]    a_head, b_head, d_head;
    logic [IW-1:0]         a_id, b_id, d_id, ab_id;
    logic                  a_full, b_full, d_full;
    logic                  a_empty, b_empty, d_empty;
    logic [fifoPtrWidth:0] a_count, b_count, d_count;
    logic                  a_pop, b_pop, d_pop;
    logic                  advance;
    src_e                  ab_sel, sel;

    logic                   out_valid_q, out_valid_d;
    logic [formatWidth-1:0] out_format_q, out_format_d;
    logic [IW-1:0]          out_maj_id_q, out_maj_id_d;
    logic [payloadWidth-1:0] out_payload_q, out_payload_d;

    decode_format_fifo #(
        .WIDTH(ENTRY_W), .DEPTH(fifoDepth), .PTR_W(fifoPtrWidth)
    ) u_fifo_a (
        .clk_i(clock_i), .rst_ni(reset_i), .flush_i(flush_i),
        .push_i(AEnable_i), .pop_i(a_pop),
        .data_i({AMajId_i, APayload_i}), .head_o(a_head),
        .full_o(a_full), .empty_o(a_empty), .count_o(a_count)
    );

    decode_format_fifo #(
        .WIDTH(ENTRY_W), .DEPTH(fifoDepth), .PTR_W(fifoPtrWidth)
    ) u_fifo_b (
        .clk_i(clock_i), .rst_ni(reset_i), .flush_i(flush_i),
        .push_i(BEnable_i), .pop_i(b_pop),
        .data_i({BMajId_i, BPayload_i}), .head_o(b_head),
        .full_o(b_full), .empty_o(b_empty), .count_o(b_count)
    );

    decode_format_fifo #(
        .WIDTH(ENTRY_W), .DEPTH(fifoDepth), .PTR_W(fifoPtrWidth)
    ) u_fifo_d (
        .clk_i(clock_i), .rst_ni(reset_i), .flush_i(flush_i),
        .push_i(DEnable_i), .pop_i(d_pop),
        .data_i({DMajId_i, DPayload_i}), .head_o(d_head),
        .full_o(d_full), .empty_o(d_empty), .count_o(d_count)
    );

    assign AReady_o = !a_full;
    assign BReady_o = !b_full;
    assign DReady_o = !d_full;

    assign a_id = a_head[ENTRY_W-1 -: IW];
    assign b_id = b_head[ENTRY_W-1 -: IW];
    assign d_id = d_head[ENTRY_W-1 -: IW];

    assign advance = !out_valid_q || outReady_i;

    // Two-level compare tree; "<=" keeps A ahead of B ahead of D on ties.
    always_comb begin
        ab_sel = SRC_NONE;
        ab_id  = '0;
        sel    = SRC_NONE;
        if (!a_empty && (b_empty || a_id <= b_id)) begin
            ab_sel = SRC_A;
            ab_id  = a_id;
        end else if (!b_empty) begin
            ab_sel = SRC_B;
            ab_id  = b_id;
        end
        if (ab_sel != SRC_NONE && (d_empty || ab_id <= d_id)) begin
            sel = ab_sel;
        end else if (!d_empty) begin
            sel = SRC_D;
        end
    end

    assign a_pop = advance && (sel == SRC_A);
    assign b_pop = advance && (sel == SRC_B);
    assign d_pop = advance && (sel == SRC_D);

    always_comb begin
        out_valid_d   = out_valid_q;
        out_format_d  = out_format_q;
        out_maj_id_d  = out_maj_id_q;
        out_payload_d = out_payload_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = (sel != SRC_NONE);
            unique case (sel)
                SRC_A: begin
                    out_format_d                  = formatWidth'(FMT_A);
                    {out_maj_id_d, out_payload_d} = a_head;
                end
                SRC_B: begin
                    out_format_d                  = formatWidth'(FMT_B);
                    {out_maj_id_d, out_payload_d} = b_head;
                end
                SRC_D: begin
                    out_format_d                  = formatWidth'(FMT_D);
                    {out_maj_id_d, out_payload_d} = d_head;
                end
                default: begin
                    out_format_d = out_format_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            out_valid_q   <= 1'b0;
            out_format_q  <= '0;
            out_maj_id_q  <= '0;
            out_payload_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_format_q  <= out_format_d;
            out_maj_id_q  <= out_maj_id_d;
            out_payload_q <= out_payload_d;
        end
    end

    assign outValid_o   = out_valid_q;
    assign outFormat_o  = out_format_q;
    assign outMajId_o   = out_maj_id_q;
    assign outPayload_o = out_payload_q;
    assign occupancy_o  = OCC_W'(a_count) + OCC_W'(b_count)
                        + OCC_W'(d_count) + OCC_W'(out_valid_q);

endmodule
